// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the SRAM port arbiter, its two requesters and the SRAM port.
//
// Port summary
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 : requester access, held until grant
//   gnt0/gnt1                                      : access accepted this cycle
//   rvalid0/rvalid1, rdata0/rdata1                 : tagged read return, one cycle after grant
//   mem_we, mem_addr, mem_din                      : arbiter -> SRAM port
//   mem_dout                                       : SRAM port -> arbiter (registered read)
//
// Modports
//   slave  : arbiter view (serves the requesters, drives the SRAM port)
//   master : environment view (requesters and SRAM model)
interface sram_port_arbiter_if #(
    parameter int unsigned DWIDTH = 72,
    parameter int unsigned AWIDTH = 8
);
    logic              req0;
    logic              we0;
    logic [AWIDTH-1:0] addr0;
    logic [DWIDTH-1:0] wdata0;
    logic              gnt0;
    logic              rvalid0;
    logic [DWIDTH-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [AWIDTH-1:0] addr1;
    logic [DWIDTH-1:0] wdata1;
    logic              gnt1;
    logic              rvalid1;
    logic [DWIDTH-1:0] rdata1;

    logic              mem_we;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_din;
    logic [DWIDTH-1:0] mem_dout;

    modport slave (
        input  req0, we0, addr0, wdata0,
        output gnt0, rvalid0, rdata0,
        input  req1, we1, addr1, wdata1,
        output gnt1, rvalid1, rdata1,
        output mem_we, mem_addr, mem_din,
        input  mem_dout
    );

    modport master (
        output req0, we0, addr0, wdata0,
        input  gnt0, rvalid0, rdata0,
        output req1, we1, addr1, wdata1,
        input  gnt1, rvalid1, rdata1,
        input  mem_we, mem_addr, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one port of a dual-port SRAM (1-cycle registered read, read-first)
// between two requesters (req0 = RISC-V core, req1 = HW accelerator).
// Round-robin arbitration, one access per cycle, per-requester read-return tags.
// A clear sequencer zero-fills the whole array after reset (CLEAR_ON_RESET) or
// on a clear_req pulse, so the memory needs no file-based initialisation.
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   asynchronous, active-high
//   clear_req  in   1-cycle pulse, start a zero-fill sweep (ignored while sweeping)
//   busy       out  high while the sweep runs
//   bus        slave modport of sram_port_arbiter_if (requesters + SRAM port)
module sram_port_arbiter #(
    parameter int unsigned DWIDTH         = 72,
    parameter int unsigned AWIDTH         = 8,
    parameter int unsigned DEPTH          = 2**AWIDTH,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear_req,
    output logic                busy,
    sram_port_arbiter_if.slave  bus
);

    typedef enum logic {
        ST_CLEAR,
        ST_ARB
    } state_t;

    localparam state_t            ST_RESET  = CLEAR_ON_RESET ? ST_CLEAR : ST_ARB;
    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic              rr_ptr_q, rr_ptr_d;     // 0: req0 wins a tie, 1: req1 wins
    logic              rd_valid_q, rd_valid_d; // a read was granted last cycle
    logic              rd_tag_q, rd_tag_d;     // which requester owns that read

    logic              gnt0_c, gnt1_c;
    logic              mem_we_c;
    logic [AWIDTH-1:0] mem_addr_c;
    logic [DWIDTH-1:0] mem_din_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RESET;
            clr_cnt_q  <= '0;
            rr_ptr_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_tag_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            rd_valid_q <= rd_valid_d;
            rd_tag_q   <= rd_tag_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        rd_valid_d = 1'b0;
        rd_tag_d   = rd_tag_q;
        gnt0_c     = 1'b0;
        gnt1_c     = 1'b0;
        mem_we_c   = 1'b0;
        mem_addr_c = '0;
        mem_din_c  = '0;

        case (state_q)
            ST_CLEAR: begin
                mem_we_c   = 1'b1;
                mem_addr_c = clr_cnt_q;
                if (clr_cnt_q == LAST_ADDR) begin
                    clr_cnt_d = '0;
                    state_d   = ST_ARB;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end

            ST_ARB: begin
                // A clear request owns its cycle: nothing is granted alongside it.
                if (clear_req) begin
                    state_d = ST_CLEAR;
                end else begin
                    gnt0_c = bus.req0 & (~bus.req1 | ~rr_ptr_q);
                    gnt1_c = bus.req1 & (~bus.req0 |  rr_ptr_q);
                    if (gnt0_c) begin
                        mem_we_c   = bus.we0;
                        mem_addr_c = bus.addr0;
                        mem_din_c  = bus.wdata0;
                        rr_ptr_d   = 1'b1;
                        rd_valid_d = ~bus.we0;
                        rd_tag_d   = 1'b0;
                    end else if (gnt1_c) begin
                        mem_we_c   = bus.we1;
                        mem_addr_c = bus.addr1;
                        mem_din_c  = bus.wdata1;
                        rr_ptr_d   = 1'b0;
                        rd_valid_d = ~bus.we1;
                        rd_tag_d   = 1'b1;
                    end
                end
            end

            default: state_d = ST_RESET;
        endcase
    end

    // Reset is asynchronous, so grants and SRAM writes are also masked
    // combinationally while it is held, not only after the next edge.
    assign bus.gnt0     = gnt0_c & ~reset;
    assign bus.gnt1     = gnt1_c & ~reset;
    assign bus.mem_we   = mem_we_c & ~reset;
    assign bus.mem_addr = mem_addr_c;
    assign bus.mem_din  = mem_din_c;

    // The SRAM output is registered, so the returning data lines up with the
    // tag captured at grant time; rdata of the non-valid requester is don't-care.
    assign bus.rvalid0  = rd_valid_q & ~rd_tag_q;
    assign bus.rvalid1  = rd_valid_q &  rd_tag_q;
    assign bus.rdata0   = bus.mem_dout;
    assign bus.rdata1   = bus.mem_dout;

    assign busy = (state_q == ST_CLEAR);

endmodule
